// File: rtl/berger_scrub_memory.sv
// Berger-coded word memory with a background scrubber that counts mismatches.
// Optional write-path error injection is enabled by defining BERGER_ERR_INJECT_EN.
module berger_scrub_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef BERGER_ERR_INJECT_EN
  input  logic [DATA_W-1:0] inj_mask,
`endif
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              scrub_start,
  output logic              scrub_busy,
  output logic              scrub_done,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_seen
);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CHK_W  = $clog2(DATA_W + 1);
  localparam int WORD_W = DATA_W + CHK_W;
  localparam logic [WORD_W-1:0] RST_WORD = {CHK_W'(DATA_W), {DATA_W{1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;

  function automatic logic [CHK_W-1:0] zero_cnt(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) c = c + {{(CHK_W-1){1'b0}}, ~d[i]};
    return c;
  endfunction

  function automatic logic word_err(input logic [WORD_W-1:0] w);
    return zero_cnt(w[DATA_W-1:0]) != w[WORD_W-1:DATA_W];
  endfunction

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] store_data_s;
  logic              rd_valid_q, rd_err_q;
  logic [DATA_W-1:0] rd_data_q;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, first_q, first_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              seen_q, seen_d;
  logic              start_s, step_s, hit_s;

`ifdef BERGER_ERR_INJECT_EN
  assign store_data_s = wr_data ^ inj_mask;
`else
  assign store_data_s = wr_data;
`endif

  // Storage array; the check field always comes from the un-injected data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_WORD;
    end else if (wr_en) begin
      mem_q[wr_addr] <= {zero_cnt(wr_data), store_data_s};
    end
  end

  // Registered read port, read-first against a same-cycle write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= mem_q[rd_addr][DATA_W-1:0];
        rd_err_q  <= word_err(mem_q[rd_addr]);
      end
    end
  end

  assign start_s = (state_q == IDLE) && scrub_start;
  assign step_s  = (state_q == SCAN) && !rd_en && !wr_en;
  assign hit_s   = step_s && word_err(mem_q[ptr_q]);

  // Scrub state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Scrub next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (scrub_start) state_d = SCAN; else state_d = IDLE;
      SCAN:    if (step_s && (&ptr_q)) state_d = DONE; else state_d = SCAN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scrub outputs decoded from state
  always_comb begin
    scrub_busy = 1'b0;
    scrub_done = 1'b0;
    case (state_q)
      SCAN:    scrub_busy = 1'b1;
      DONE:    scrub_done = 1'b1;
      default: begin
        scrub_busy = 1'b0;
        scrub_done = 1'b0;
      end
    endcase
  end

  // Pointer and error statistics; stats persist in IDLE until the next pass
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    seen_d  = seen_q;
    if (start_s) begin
      ptr_d  = '0;
      cnt_d  = 8'd0;
      seen_d = 1'b0;
    end else if (step_s) begin
      ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (hit_s) begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        else                cnt_d = cnt_q;
        if (!seen_q) begin
          first_d = ptr_q;
          seen_d  = 1'b1;
        end else begin
          first_d = first_q;
        end
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Scrub datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      cnt_q   <= 8'd0;
      first_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      seen_q  <= seen_d;
    end
  end

  assign rd_valid       = rd_valid_q;
  assign rd_data        = rd_data_q;
  assign rd_err         = rd_err_q;
  assign err_cnt        = cnt_q;
  assign first_err_addr = first_q;
  assign err_seen       = seen_q;
endmodule
